// File: rtl/arbitro_memoria.sv
// Unified memory-port arbiter: shares one handshake port between instruction fetch and
// data access, with data priority, bounded fetch starvation and a transaction watchdog.
module arbitro_memoria #(
  parameter int MAX_DM_CONSEC = 4,
  parameter int TIMEOUT_CYC   = 64,
  parameter int AW            = 32
) (
  input  logic          clk_i,
  input  logic          reset_i,
  input  logic          if_req_i,
  input  logic [AW-1:0] if_addr_i,
  input  logic          if_flush_i,
  output logic          if_valid_o,
  output logic [31:0]   if_rdata_o,
  input  logic          dm_req_i,
  input  logic          dm_we_i,
  input  logic [AW-1:0] dm_addr_i,
  input  logic [31:0]   dm_wdata_i,
  output logic          dm_valid_o,
  output logic [31:0]   dm_rdata_o,
  output logic          mem_req_o,
  output logic          mem_we_o,
  output logic [AW-1:0] mem_addr_o,
  output logic [31:0]   mem_wdata_o,
  input  logic [31:0]   mem_rdata_i,
  input  logic          mem_ack_i,
  output logic          stall_f_o,
  output logic          stall_m_o,
  output logic          timeout_o
);

  localparam int              WDW      = (TIMEOUT_CYC > 2) ? $clog2(TIMEOUT_CYC) : 1;
  localparam logic [WDW-1:0]  WD_LAST  = WDW'((TIMEOUT_CYC > 0) ? (TIMEOUT_CYC - 1) : 0);
  localparam logic            WD_EN    = (TIMEOUT_CYC > 0);
  localparam logic [3:0]      DM_MAX   = 4'(MAX_DM_CONSEC);
  localparam logic [31:0]     NOP_INSN = 32'h0000_0013;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_MEM_IF  = 3'd1,
    ST_MEM_DM  = 3'd2,
    ST_RESP_IF = 3'd3,
    ST_RESP_DM = 3'd4
  } state_e;

  state_e          state_q, state_d;
  logic [3:0]      dm_cnt_q, dm_cnt_d;
  logic [WDW-1:0]  wd_cnt_q, wd_cnt_d;
  logic            cancel_q, cancel_d;
  logic            mem_req_q, mem_req_d;
  logic            mem_we_q, mem_we_d;
  logic [AW-1:0]   mem_addr_q, mem_addr_d;
  logic [31:0]     mem_wdata_q, mem_wdata_d;
  logic [31:0]     if_rdata_q, if_rdata_d;
  logic [31:0]     dm_rdata_q, dm_rdata_d;
  logic            timeout_q, timeout_d;

  function automatic logic [3:0] sat_inc(input logic [3:0] cnt);
    if (cnt < DM_MAX) begin
      sat_inc = cnt + 4'd1;
    end else begin
      sat_inc = DM_MAX;
    end
  endfunction

  // Grant decision, memory handshake sequencing, watchdog and response capture
  always_comb begin
    state_d     = state_q;
    dm_cnt_d    = dm_cnt_q;
    wd_cnt_d    = '0;
    cancel_d    = cancel_q;
    mem_req_d   = mem_req_q;
    mem_we_d    = mem_we_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    if_rdata_d  = if_rdata_q;
    dm_rdata_d  = dm_rdata_q;
    timeout_d   = 1'b0;

    case (state_q)
      ST_IDLE: begin
        cancel_d = 1'b0;
        if (!if_req_i) begin
          dm_cnt_d = 4'd0;
        end else begin
          dm_cnt_d = dm_cnt_q;
        end
        // Data wins unless fetch has waited through DM_MAX consecutive data grants
        if (dm_req_i && ((dm_cnt_q < DM_MAX) || !if_req_i)) begin
          state_d     = ST_MEM_DM;
          mem_req_d   = 1'b1;
          mem_we_d    = dm_we_i;
          mem_addr_d  = dm_addr_i;
          mem_wdata_d = dm_wdata_i;
          dm_cnt_d    = if_req_i ? sat_inc(dm_cnt_q) : 4'd0;
        end else if (if_req_i && !if_flush_i) begin
          state_d     = ST_MEM_IF;
          mem_req_d   = 1'b1;
          mem_we_d    = 1'b0;
          mem_addr_d  = if_addr_i;
          mem_wdata_d = 32'h0000_0000;
          dm_cnt_d    = 4'd0;
        end else begin
          state_d = ST_IDLE;
        end
      end

      ST_MEM_IF, ST_MEM_DM: begin
        wd_cnt_d = wd_cnt_q + WDW'(1);
        if ((state_q == ST_MEM_IF) && if_flush_i) begin
          cancel_d = 1'b1;
        end else begin
          cancel_d = cancel_q;
        end
        if (mem_ack_i) begin
          mem_req_d = 1'b0;
          mem_we_d  = 1'b0;
          wd_cnt_d  = '0;
          if (state_q == ST_MEM_IF) begin
            state_d    = ST_RESP_IF;
            if_rdata_d = mem_rdata_i;
          end else begin
            state_d    = ST_RESP_DM;
            dm_rdata_d = mem_rdata_i;
          end
        end else if (WD_EN && (wd_cnt_q == WD_LAST)) begin
          // Abort: the requester still gets its response, carrying a harmless value
          mem_req_d = 1'b0;
          mem_we_d  = 1'b0;
          wd_cnt_d  = '0;
          timeout_d = 1'b1;
          if (state_q == ST_MEM_IF) begin
            state_d    = ST_RESP_IF;
            if_rdata_d = NOP_INSN;
          end else begin
            state_d    = ST_RESP_DM;
            dm_rdata_d = 32'h0000_0000;
          end
        end else begin
          state_d = state_q;
        end
      end

      ST_RESP_IF, ST_RESP_DM: begin
        state_d  = ST_IDLE;
        cancel_d = 1'b0;
      end

      default: begin
        state_d   = ST_IDLE;
        mem_req_d = 1'b0;
        mem_we_d  = 1'b0;
        cancel_d  = 1'b0;
      end
    endcase
  end

  // State and datapath registers
  always_ff @(posedge clk_i or negedge reset_i) begin
    if (!reset_i) begin
      state_q     <= ST_IDLE;
      dm_cnt_q    <= 4'd0;
      wd_cnt_q    <= '0;
      cancel_q    <= 1'b0;
      mem_req_q   <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= 32'h0000_0000;
      if_rdata_q  <= 32'h0000_0000;
      dm_rdata_q  <= 32'h0000_0000;
      timeout_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      dm_cnt_q    <= dm_cnt_d;
      wd_cnt_q    <= wd_cnt_d;
      cancel_q    <= cancel_d;
      mem_req_q   <= mem_req_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      if_rdata_q  <= if_rdata_d;
      dm_rdata_q  <= dm_rdata_d;
      timeout_q   <= timeout_d;
    end
  end

  // A flush arriving during the response cycle still kills that fetch's valid
  assign if_valid_o  = (state_q == ST_RESP_IF) && !cancel_q && !if_flush_i;
  assign dm_valid_o  = (state_q == ST_RESP_DM);
  assign if_rdata_o  = if_rdata_q;
  assign dm_rdata_o  = dm_rdata_q;
  assign mem_req_o   = mem_req_q;
  assign mem_we_o    = mem_we_q;
  assign mem_addr_o  = mem_addr_q;
  assign mem_wdata_o = mem_wdata_q;
  assign timeout_o   = timeout_q;
  assign stall_f_o   = if_req_i & ~if_valid_o & ~if_flush_i;
  assign stall_m_o   = dm_req_i & ~dm_valid_o;

endmodule

// File: tb/tb_arbitro_memoria.sv
// Randomized bench for arbitro_memoria: bench-side requesters and memory, checked every
// cycle against a transaction-timeline reference model.
module tb_arbitro_memoria;

  localparam int AW   = 32;
  localparam int MAXC = 4;
  localparam int TOC  = 8;
  localparam int NCYC = 3000;

  logic          clk_i = 1'b0;
  logic          reset_i;
  logic          if_req_i, if_flush_i, if_valid_o;
  logic [AW-1:0] if_addr_i;
  logic [31:0]   if_rdata_o;
  logic          dm_req_i, dm_we_i, dm_valid_o;
  logic [AW-1:0] dm_addr_i;
  logic [31:0]   dm_wdata_i, dm_rdata_o;
  logic          mem_req_o, mem_we_o, mem_ack_i;
  logic [AW-1:0] mem_addr_o;
  logic [31:0]   mem_wdata_o, mem_rdata_i;
  logic          stall_f_o, stall_m_o, timeout_o;

  arbitro_memoria #(.MAX_DM_CONSEC(MAXC), .TIMEOUT_CYC(TOC), .AW(AW)) dut (
    .clk_i(clk_i), .reset_i(reset_i),
    .if_req_i(if_req_i), .if_addr_i(if_addr_i), .if_flush_i(if_flush_i),
    .if_valid_o(if_valid_o), .if_rdata_o(if_rdata_o),
    .dm_req_i(dm_req_i), .dm_we_i(dm_we_i), .dm_addr_i(dm_addr_i), .dm_wdata_i(dm_wdata_i),
    .dm_valid_o(dm_valid_o), .dm_rdata_o(dm_rdata_o),
    .mem_req_o(mem_req_o), .mem_we_o(mem_we_o), .mem_addr_o(mem_addr_o),
    .mem_wdata_o(mem_wdata_o), .mem_rdata_i(mem_rdata_i), .mem_ack_i(mem_ack_i),
    .stall_f_o(stall_f_o), .stall_m_o(stall_m_o), .timeout_o(timeout_o)
  );

  always #5 clk_i = ~clk_i;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%h exp=%h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Requester state (bench acts as the pipeline)
  logic        if_pend, dm_pend, dm_we_m;
  logic [31:0] if_addr_m, dm_addr_m, dm_wdata_m;

  // Reference timeline: one memory transaction in flight, then one response cycle
  logic        busy, resp;
  logic        tx_if, tx_we, tx_cancel;
  logic [31:0] tx_addr, tx_wdata;
  int          tx_age, ack_at;
  logic        resp_if, resp_we, resp_cancel, resp_to;
  logic [31:0] resp_data;
  int          dm_run;
  int          n_timeouts = 0;
  int          n_if_grants = 0;

  function automatic int pick_ack();
    int r;
    r = int'($urandom_range(0, 9));
    if (r <= 6)      pick_ack = int'($urandom_range(0, 3));
    else if (r == 7) pick_ack = TOC - 1;
    else if (r == 8) pick_ack = TOC - 2;
    else             pick_ack = -1;
  endfunction

  task automatic drive_cycle();
    if (!if_pend && ($urandom_range(0, 3) != 0)) begin
      if_pend   = 1'b1;
      if_addr_m = $urandom & 32'hFFFF_FFFC;
    end
    if (!dm_pend && ($urandom_range(0, 2) != 0)) begin
      dm_pend    = 1'b1;
      dm_we_m    = 1'($urandom_range(0, 1));
      dm_addr_m  = $urandom;
      dm_wdata_m = $urandom;
    end
    if_req_i    = if_pend;
    if_addr_i   = if_pend ? if_addr_m : $urandom;
    dm_req_i    = dm_pend;
    dm_we_i     = dm_pend ? dm_we_m : 1'($urandom_range(0, 1));
    dm_addr_i   = dm_pend ? dm_addr_m : $urandom;
    dm_wdata_i  = dm_pend ? dm_wdata_m : $urandom;
    if_flush_i  = ($urandom_range(0, 11) == 0);
    mem_ack_i   = busy ? (ack_at == tx_age) : ($urandom_range(0, 4) == 0);
    mem_rdata_i = $urandom;
  endtask

  task automatic check_and_step();
    logic exp_ifv, exp_dmv;
    exp_ifv = resp && resp_if && !resp_cancel && !if_flush_i;
    exp_dmv = resp && !resp_if;

    check_val("mem_req", 32'(mem_req_o), 32'(busy));
    check_val("if_valid", 32'(if_valid_o), 32'(exp_ifv));
    check_val("dm_valid", 32'(dm_valid_o), 32'(exp_dmv));
    check_val("timeout", 32'(timeout_o), 32'(resp && resp_to));
    check_val("stall_f", 32'(stall_f_o), 32'(if_req_i && !exp_ifv && !if_flush_i));
    check_val("stall_m", 32'(stall_m_o), 32'(dm_req_i && !exp_dmv));
    if (busy) begin
      check_val("mem_addr", mem_addr_o, tx_addr);
      check_val("mem_we", 32'(mem_we_o), 32'(tx_we));
      if (tx_we) check_val("mem_wdata", mem_wdata_o, tx_wdata);
    end
    if (exp_ifv) check_val("if_rdata", if_rdata_o, resp_data);
    if (exp_dmv && !resp_we) check_val("dm_rdata", dm_rdata_o, resp_data);

    if (resp) begin
      resp = 1'b0;
      if (exp_ifv) if_pend = 1'b0;
      if (exp_dmv) dm_pend = 1'b0;
    end else if (busy) begin
      if (tx_if && if_flush_i) tx_cancel = 1'b1;
      if (mem_ack_i || (tx_age == TOC - 1)) begin
        busy        = 1'b0;
        resp        = 1'b1;
        resp_if     = tx_if;
        resp_we     = tx_we;
        resp_cancel = tx_cancel;
        resp_to     = !mem_ack_i;
        resp_data   = mem_ack_i ? mem_rdata_i : (tx_if ? 32'h0000_0013 : 32'h0000_0000);
        if (resp_to) n_timeouts++;
      end else begin
        tx_age++;
      end
    end else begin
      if (!if_req_i) dm_run = 0;
      if (dm_req_i && (dm_run < MAXC || !if_req_i)) begin
        busy = 1'b1; tx_if = 1'b0; tx_we = dm_we_i; tx_addr = dm_addr_i; tx_wdata = dm_wdata_i;
        if (if_req_i && dm_run < MAXC) dm_run++;
      end else if (if_req_i && !if_flush_i) begin
        busy = 1'b1; tx_if = 1'b1; tx_we = 1'b0; tx_addr = if_addr_i; tx_wdata = 32'h0;
        dm_run = 0;
        n_if_grants++;
      end
      if (busy) begin
        tx_age    = 0;
        tx_cancel = 1'b0;
        ack_at    = pick_ack();
      end
    end
    // A flushed fetch is abandoned; the requester redirects to a new address later
    if (if_flush_i) if_pend = 1'b0;
  endtask

  task automatic mid_reset();
    #2 reset_i = 1'b0;
    #1;
    check_val("rst_async_mem_req", 32'(mem_req_o), 32'h0);
    check_val("rst_async_if_valid", 32'(if_valid_o), 32'h0);
    check_val("rst_async_dm_valid", 32'(dm_valid_o), 32'h0);
    check_val("rst_async_timeout", 32'(timeout_o), 32'h0);
    busy = 1'b0; resp = 1'b0; dm_run = 0;
    @(posedge clk_i);
    #1 reset_i = 1'b1;
  endtask

  initial begin
    int n_resets;
    n_resets = 0;
    reset_i = 1'b0;
    if_req_i = 1'b0; if_addr_i = '0; if_flush_i = 1'b0;
    dm_req_i = 1'b0; dm_we_i = 1'b0; dm_addr_i = '0; dm_wdata_i = 32'h0;
    mem_ack_i = 1'b0; mem_rdata_i = 32'h0;
    if_pend = 1'b0; dm_pend = 1'b0; dm_we_m = 1'b0;
    if_addr_m = 32'h0; dm_addr_m = 32'h0; dm_wdata_m = 32'h0;
    busy = 1'b0; resp = 1'b0; dm_run = 0;
    tx_if = 1'b0; tx_we = 1'b0; tx_cancel = 1'b0; tx_addr = 32'h0; tx_wdata = 32'h0;
    tx_age = 0; ack_at = 0;
    resp_if = 1'b0; resp_we = 1'b0; resp_cancel = 1'b0; resp_to = 1'b0; resp_data = 32'h0;

    repeat (3) @(posedge clk_i);
    @(negedge clk_i);
    check_val("rst_mem_req", 32'(mem_req_o), 32'h0);
    check_val("rst_mem_we", 32'(mem_we_o), 32'h0);
    check_val("rst_mem_addr", mem_addr_o, 32'h0);
    check_val("rst_mem_wdata", mem_wdata_o, 32'h0);
    check_val("rst_if_rdata", if_rdata_o, 32'h0);
    check_val("rst_dm_rdata", dm_rdata_o, 32'h0);
    check_val("rst_if_valid", 32'(if_valid_o), 32'h0);
    check_val("rst_dm_valid", 32'(dm_valid_o), 32'h0);
    check_val("rst_timeout", 32'(timeout_o), 32'h0);
    @(posedge clk_i);
    #1 reset_i = 1'b1;

    for (int cyc = 0; cyc < NCYC; cyc++) begin
      drive_cycle();
      @(negedge clk_i);
      check_and_step();
      @(posedge clk_i);
      #1;
      if (busy && !tx_if && ((n_resets == 0 && cyc >= 1000) || (n_resets == 1 && cyc >= 2000))) begin
        mid_reset();
        n_resets++;
      end
    end

    check_val("mid_resets_applied", 32'(n_resets), 32'd2);
    if (n_timeouts == 0) check_val("timeouts_seen", 32'(n_timeouts), 32'd1);
    if (n_if_grants == 0) check_val("if_grants_seen", 32'(n_if_grants), 32'd1);
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
